cfu_cmd_master: RTL

- Hardware initiator for the CFU cmd/rsp interface; it drives the port the CPU normally drives.
- Runs one dot-product job: one INIT command (load input offset, clear accumulator), then LEN MAC commands fed from an operand stream.
- Captures the final accumulator response and reports it as the job result.
- Sits between a DMA/operand-fetch block and a CFU instance, so a layer's inner loop runs without CPU involvement.

---
 rtl/cfu_cmd_master.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cfu_cmd_master.sv
// Hardware initiator for the CFU cmd/rsp port: runs one INIT command followed by LEN MAC
// commands fed from a small operand FIFO, and reports the final accumulator response.
module cfu_cmd_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16,
    parameter logic [9:0]  FID_INIT   = 10'd2,
    parameter logic [9:0]  FID_MAC    = 10'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      job_offset,
    input  logic [LEN_W-1:0] job_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_payload_outputs_0
);

    localparam int unsigned    PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT_CMD = 3'd1;
    localparam logic [2:0] S_INIT_RSP = 3'd2;
    localparam logic [2:0] S_MAC_CMD  = 3'd3;
    localparam logic [2:0] S_MAC_RSP  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [15:0]      offset_q;
    logic [LEN_W-1:0] len_q, accepted_q, issued_q;
    logic [31:0]      result_q;
    logic [31:0]      fifo_a_q [FIFO_DEPTH];
    logic [31:0]      fifo_b_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic fifo_empty, fifo_full, push, pop, cmd_fire;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign rsp_ready  = (state_q == S_INIT_RSP) || (state_q == S_MAC_RSP);
    // Intake stops once len pairs are taken, so surplus operands stay upstream.
    assign op_ready   = busy && !fifo_full && (accepted_q < len_q);
    assign push       = op_valid && op_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign pop        = (state_q == S_MAC_CMD) && cmd_fire;

    always_comb begin
        cmd_valid               = 1'b0;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0    = 32'd0;
        cmd_payload_inputs_1    = 32'd0;
        case (state_q)
            S_INIT_CMD: begin
                cmd_valid               = 1'b1;
                cmd_payload_function_id = FID_INIT;
                cmd_payload_inputs_0    = {16'd0, offset_q};
            end
            S_MAC_CMD: begin
                cmd_valid               = !fifo_empty;
                cmd_payload_function_id = FID_MAC;
                cmd_payload_inputs_0    = fifo_a_q[rd_ptr_q];
                cmd_payload_inputs_1    = fifo_b_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_INIT_CMD;
            S_INIT_CMD: if (cmd_fire) state_d = S_INIT_RSP;
            S_INIT_RSP: if (rsp_valid) state_d = (len_q != '0) ? S_MAC_CMD : S_DONE;
            S_MAC_CMD:  if (cmd_fire) state_d = S_MAC_RSP;
            S_MAC_RSP:  if (rsp_valid) state_d = (issued_q == len_q) ? S_DONE : S_MAC_CMD;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            offset_q   <= '0;
            len_q      <= '0;
            accepted_q <= '0;
            issued_q   <= '0;
            result_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                offset_q   <= job_offset;
                len_q      <= job_len;
                accepted_q <= '0;
                issued_q   <= '0;
            end
            if (push) accepted_q <= accepted_q + 1'b1;
            if (pop) issued_q <= issued_q + 1'b1;
            if ((state_q == S_INIT_RSP) && rsp_valid && (len_q == '0)) result_q <= '0;
            if ((state_q == S_MAC_RSP) && rsp_valid) result_q <= rsp_payload_outputs_0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_a_q[i] <= '0;
                fifo_b_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_a_q[wr_ptr_q] <= op_a;
                fifo_b_q[wr_ptr_q] <= op_b;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
